qos: RTL and testbench

- Quality-of-service scheduler. Four input FIFO queues share one output port, served by weighted round-robin.
- Upstream agents push bytes into per-queue FIFOs.
- A programmable arbitration table of 8 entries decides which queue is served and for how many consecutive words.
- Sits between traffic sources and a single egress link.

---
 rtl/qos_pkg.sv | 32 +++
 rtl/qos_fifo.sv | 66 ++++++
 rtl/qos.sv | 115 +++++++++++
 tb/tb_qos.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/qos_pkg.sv
// Shared constants and types for the four-queue weighted round-robin scheduler.
package qos_pkg;

  localparam int unsigned QUEUE_QUANTITY = 4;
  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BUF_WIDTH      = 3;
  localparam int unsigned MAX_WEIGHT     = 64;
  localparam int unsigned TABLE_SIZE     = 8;

  localparam int unsigned QIDX_W   = 2;
  localparam int unsigned WEIGHT_W = 7;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned CNT_W    = BUF_WIDTH + 1;

  typedef struct packed {
    logic [QIDX_W-1:0]   queue;
    logic [WEIGHT_W-1:0] weight;
  } tbl_entry_t;

  // Reset contents: plain round-robin, one word per visit.
  function automatic tbl_entry_t default_entry(input int idx);
    tbl_entry_t e;
    e.queue  = QIDX_W'(idx % QUEUE_QUANTITY);
    e.weight = WEIGHT_W'(1);
    return e;
  endfunction

  function automatic logic [WEIGHT_W-1:0] clamp_weight(input logic [WEIGHT_W-1:0] w);
    return (w > WEIGHT_W'(MAX_WEIGHT)) ? WEIGHT_W'(MAX_WEIGHT) : w;
  endfunction

endpackage

// File: rtl/qos_fifo.sv
// Synchronous FIFO with registered full/empty flags derived from an occupancy count.
module qos_fifo
  import qos_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam int unsigned Depth = 2 ** BUF_WIDTH;

  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [BUF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [BUF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 push_acc, pop_acc;

  always_comb begin
    push_acc = push_i & ~full_q;
    pop_acc  = pop_i & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + BUF_WIDTH'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + BUF_WIDTH'(1);
    if (push_acc && !pop_acc) count_d = count_q + CNT_W'(1);
    if (pop_acc && !push_acc) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(Depth));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/qos.sv
// Four-queue scheduler: per-queue FIFOs drained onto one egress port by a programmable
// weighted round-robin table.
module qos
  import qos_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           push,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  output logic [QUEUE_QUANTITY-1:0]           full,
  output logic [QUEUE_QUANTITY-1:0]           empty,
  input  logic                                out_ready,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                valid_out,
  output logic [QIDX_W-1:0]                   queue_sel,
  input  logic                                tbl_wr_en,
  input  logic [PTR_W-1:0]                    tbl_wr_addr,
  input  logic [QIDX_W-1:0]                   tbl_wr_queue,
  input  logic [WEIGHT_W-1:0]                 tbl_wr_weight
);

  tbl_entry_t           tbl_q [TABLE_SIZE];
  tbl_entry_t           tbl_d [TABLE_SIZE];
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic [QIDX_W-1:0]    sel_q, sel_d;

  logic [QUEUE_QUANTITY-1:0] pop;
  logic [DATA_BITS-1:0]      fifo_rdata [QUEUE_QUANTITY];
  logic [CNT_W-1:0]          fifo_count [QUEUE_QUANTITY];

  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_fifo
    qos_fifo u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push[g]),
      .wdata_i (data_in[g*DATA_BITS +: DATA_BITS]),
      .pop_i   (pop[g]),
      .rdata_o (fifo_rdata[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .count_o (fifo_count[g])
    );
  end

  tbl_entry_t          cur;
  logic                pop_en;
  logic                last_word;
  logic [WEIGHT_W-1:0] credit_inc;

  always_comb begin
    for (int i = 0; i < TABLE_SIZE; i++) tbl_d[i] = tbl_q[i];
    if (tbl_wr_en) begin
      tbl_d[tbl_wr_addr].queue  = tbl_wr_queue;
      tbl_d[tbl_wr_addr].weight = clamp_weight(tbl_wr_weight);
    end

    cur        = tbl_q[ptr_q];
    credit_inc = credit_q + WEIGHT_W'(1);
    // The pop drains the queue unless a same-cycle push refills it.
    last_word  = (fifo_count[cur.queue] == CNT_W'(1)) &&
                 !(push[cur.queue] && !full[cur.queue]);
    ptr_d      = ptr_q;
    credit_d   = credit_q;
    pop        = '0;
    pop_en     = 1'b0;

    if (enb) begin
      if (cur.weight == '0 || empty[cur.queue]) begin
        ptr_d    = ptr_q + PTR_W'(1);
        credit_d = '0;
      end else if (out_ready) begin
        pop_en         = 1'b1;
        pop[cur.queue] = 1'b1;
        // >= also retires an entry whose weight was lowered below the running credit.
        if (credit_inc >= cur.weight || last_word) begin
          ptr_d    = ptr_q + PTR_W'(1);
          credit_d = '0;
        end else begin
          credit_d = credit_inc;
        end
      end
    end

    valid_d = pop_en;
    data_d  = pop_en ? fifo_rdata[cur.queue] : data_q;
    sel_d   = pop_en ? cur.queue : sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) tbl_q[i] <= default_entry(i);
      ptr_q    <= '0;
      credit_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
    end else begin
      for (int i = 0; i < TABLE_SIZE; i++) tbl_q[i] <= tbl_d[i];
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign queue_sel = sel_q;

endmodule

// File: tb/tb_qos.sv
// Directed bench for the qos scheduler: a cycle-exact vector table plus egress-order sequences.
module tb_qos;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [3:0]  push;
  logic [31:0] data_in;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  queue_sel;
  logic        tbl_wr_en;
  logic [2:0]  tbl_wr_addr;
  logic [1:0]  tbl_wr_queue;
  logic [6:0]  tbl_wr_weight;

  always #5 clk = ~clk;

  qos dut (
    .clk           (clk),
    .rst           (rst),
    .enb           (enb),
    .push          (push),
    .data_in       (data_in),
    .full          (full),
    .empty         (empty),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .queue_sel     (queue_sel),
    .tbl_wr_en     (tbl_wr_en),
    .tbl_wr_addr   (tbl_wr_addr),
    .tbl_wr_queue  (tbl_wr_queue),
    .tbl_wr_weight (tbl_wr_weight)
  );

  typedef struct {
    logic       push2;
    logic [7:0] din;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_sel;
    logic [3:0] exp_empty;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [9:0] got [$];
  logic [9:0] exp_q [$];
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 ns after the edge, logging egress words.
  task automatic step();
    @(posedge clk);
    #1;
    if (valid_out === 1'b1) got.push_back({queue_sel, data_out});
  endtask

  task automatic do_reset();
    rst = 1'b1; enb = 1'b1; push = '0; data_in = '0; out_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_queue = '0; tbl_wr_weight = '0;
    repeat (4) step();
    rst = 1'b0;
    got.delete();
  endtask

  task automatic wr_tbl(input logic [2:0] a, input logic [1:0] q, input logic [6:0] w);
    tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_queue = q; tbl_wr_weight = w;
    step();
    tbl_wr_en = 1'b0;
  endtask

  task automatic push_words(input logic [3:0] m, input logic [31:0] d);
    push = m; data_in = d;
    step();
    push = '0;
  endtask

  task automatic check_seq(input string name);
    int n;
    check($sformatf("%s_count", name), got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", name, i), got[i], exp_q[i]);
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1; enb = 1'b1; push = '0; data_in = '0; out_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_queue = '0; tbl_wr_weight = '0;
    repeat (4) step();
    check("rst_empty", empty, 4'b1111);
    check("rst_full", full, 4'b0000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_sel", queue_sel, 2'd0);
    rst = 1'b0;
    got.delete();
    repeat (20) step();
    check("idle_no_valid", got.size(), 0);
    check("idle_empty", empty, 4'b1111);

    // ---------------- single queue, cycle-exact vectors ----------------
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 2'd0, 4'b1011};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 8'h00, 2'd0, 4'b1011};
    vecs[2]  = '{1'b1, 8'h33, 1'b1, 8'h11, 2'd2, 4'b1011};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h11, 2'd2, 4'b1011};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 8'h11, 2'd2, 4'b1011};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h11, 2'd2, 4'b1011};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h22, 2'd2, 4'b1011};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h22, 2'd2, 4'b1011};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h22, 2'd2, 4'b1011};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h22, 2'd2, 4'b1011};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h33, 2'd2, 4'b1111};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h33, 2'd2, 4'b1111};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push    = {1'b0, vecs[i].push2, 2'b00};
      data_in = {8'h00, vecs[i].din, 16'h0000};
      step();
      check($sformatf("vec%0d_valid", i), valid_out, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
      check($sformatf("vec%0d_sel", i), queue_sel, vecs[i].exp_sel);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
    end
    push = '0;

    // ---------------- default round-robin ----------------
    do_reset();
    enb = 1'b0;
    push_words(4'b1111, {8'h30, 8'h20, 8'h10, 8'h00});
    push_words(4'b1111, {8'h31, 8'h21, 8'h11, 8'h01});
    enb = 1'b1; out_ready = 1'b1;
    repeat (16) step();
    exp_q = '{{2'd0, 8'h00}, {2'd1, 8'h10}, {2'd2, 8'h20}, {2'd3, 8'h30},
              {2'd0, 8'h01}, {2'd1, 8'h11}, {2'd2, 8'h21}, {2'd3, 8'h31}};
    check_seq("rr");
    check("rr_empty", empty, 4'b1111);

    // ---------------- weighted table ----------------
    do_reset();
    enb = 1'b0;
    wr_tbl(3'd0, 2'd0, 7'd3);
    wr_tbl(3'd1, 2'd1, 7'd1);
    for (int i = 2; i < 8; i++) wr_tbl(3'(i), 2'(i % 4), 7'd0);
    push_words(4'b0011, {16'h0, 8'hB0, 8'hA0});
    push_words(4'b0011, {16'h0, 8'hB1, 8'hA1});
    for (int i = 2; i < 6; i++) push_words(4'b0001, {24'h0, 8'hA0 + 8'(i)});
    enb = 1'b1; out_ready = 1'b1;
    repeat (24) step();
    exp_q = '{{2'd0, 8'hA0}, {2'd0, 8'hA1}, {2'd0, 8'hA2}, {2'd1, 8'hB0},
              {2'd0, 8'hA3}, {2'd0, 8'hA4}, {2'd0, 8'hA5}, {2'd1, 8'hB1}};
    check_seq("wrr");

    // ---------------- full / drop ----------------
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      push_words(4'b0010, {16'h0, 8'hC0 + 8'(i), 8'h00});
      if (i == 6) check("full_after7", full, 4'b0000);
      if (i == 7) check("full_after8", full, 4'b0010);
    end
    check("full_after9", full, 4'b0010);
    check("full_no_pop", got.size(), 0);
    out_ready = 1'b1;
    repeat (40) step();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd1, 8'hC0 + 8'(i)});
    check_seq("drop");
    check("drop_empty", empty, 4'b1111);
    check("drop_full", full, 4'b0000);

    // ---------------- enb freeze and backpressure ----------------
    do_reset();
    enb = 1'b0; out_ready = 1'b1;
    push_words(4'b1111, {8'h70, 8'h60, 8'h50, 8'h40});
    push_words(4'b1111, {8'h71, 8'h61, 8'h51, 8'h41});
    repeat (5) step();
    check("frz_no_valid", got.size(), 0);
    check("frz_empty", empty, 4'b0000);
    check("frz_full", full, 4'b0000);
    enb = 1'b1;
    repeat (3) step();
    check("frz_run3", got.size(), 3);
    out_ready = 1'b0;
    repeat (4) step();
    check("bp_hold", got.size(), 3);
    check("bp_valid_low", valid_out, 1'b0);
    enb = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("frz2_hold", got.size(), 3);
    enb = 1'b1;
    repeat (16) step();
    exp_q = '{{2'd0, 8'h40}, {2'd1, 8'h50}, {2'd2, 8'h60}, {2'd3, 8'h70},
              {2'd0, 8'h41}, {2'd1, 8'h51}, {2'd2, 8'h61}, {2'd3, 8'h71}};
    check_seq("frz");
    check("frz_end_empty", empty, 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
